// File: rtl/processor_pkg.sv
// Shared definitions for the single-cycle processor: opcodes, instruction
// field positions, datapath width and the imm7 sign-extension helper.
package processor_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RA_MSB  = 12;
  localparam int RA_LSB  = 10;
  localparam int RB_MSB  = 9;
  localparam int RB_LSB  = 7;
  localparam int RC_MSB  = 2;
  localparam int RC_LSB  = 0;
  localparam int IMM_MSB = 6;
  localparam int IMM_LSB = 0;

  function automatic logic [DATA_W-1:0] sext_imm7(input logic [6:0] imm);
    return {{(DATA_W-7){imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU: computes the write-back value and a write enable that
// is low only for NOP.
module processor_alu
  import processor_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y,
  output logic              we
);

  // Opcode decode and operation select; arithmetic wraps modulo 2^DATA_W
  always_comb begin
    y  = '0;
    we = 1'b1;
    case (op)
      OP_ADD:  y = a + b;
      OP_ADDI: y = a + imm;
      OP_SUBI: y = a - imm;
      OP_SUB:  y = a - b;
      OP_NAND: y = ~(a & b);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOP:  we = 1'b0;
      default: we = 1'b0;
    endcase
  end

endmodule

// File: rtl/processor.sv
// Single-cycle eight-register datapath: decodes the external instruction,
// writes the ALU value to rA and mirrors it on the registered result.
module processor #(
  parameter int DATA_W = processor_pkg::DATA_W,
  parameter int NREGS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             instruction,
  input  logic [NREGS*DATA_W-1:0] init_values,
  output logic [DATA_W-1:0]       result
);

  import processor_pkg::*;

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [DATA_W-1:0] result_r;

  logic [2:0]        op_s;
  logic [REG_AW-1:0] ra_s;
  logic [REG_AW-1:0] rb_s;
  logic [REG_AW-1:0] rc_s;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] alu_y_s;
  logic              alu_we_s;

  // Field extraction; operands are read from the pre-edge register state
  always_comb begin
    op_s  = instruction[OP_MSB:OP_LSB];
    ra_s  = instruction[RA_MSB:RA_LSB];
    rb_s  = instruction[RB_MSB:RB_LSB];
    rc_s  = instruction[RC_MSB:RC_LSB];
    imm_s = sext_imm7(instruction[IMM_MSB:IMM_LSB]);
  end

  processor_alu u_alu (
    .op  (op_s),
    .a   (regs_r[rb_s]),
    .b   (regs_r[rc_s]),
    .imm (imm_s),
    .y   (alu_y_s),
    .we  (alu_we_s)
  );

  // Register file with asynchronous preload from init_values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= init_values[i*DATA_W +: DATA_W];
      end
    end else if (alu_we_s) begin
      regs_r[ra_s] <= alu_y_s;
    end
  end

  // Result register holds across NOP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_r <= '0;
    end else if (alu_we_s) begin
      result_r <= alu_y_s;
    end
  end

  assign result = result_r;

endmodule

// File: tb/tb_processor.sv
// Directed self-checking bench for processor: hand-computed vectors driven
// one instruction per cycle, registers observed through OR rX,rX,rX reads.
module tb_processor;

  logic         clk;
  logic         reset;
  logic [15:0]  instruction;
  logic [127:0] init_values;
  logic [15:0]  result;

  int checks   = 0;
  int failures = 0;

  logic [15:0] pre [8];

  processor dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .init_values (init_values),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] c);
    return {op, a, b, 4'b0000, c};
  endfunction

  function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [6:0] imm);
    return {op, a, b, imm};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] instr, input logic [15:0] exp);
    @(negedge clk);
    instruction = instr;
    @(posedge clk);
    #1;
    chk(tag, result, exp);
  endtask

  task automatic read_reg(input logic [2:0] r, input logic [15:0] exp);
    step($sformatf("read_r%0d", r), rrr(3'b110, r, r, r), exp);
  endtask

  initial begin
    pre = '{16'd10, 16'd20, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 8; i++) init_values[i*16 +: 16] = pre[i];
    reset       = 1'b0;
    instruction = rrr(3'b000, 3'd0, 3'd1, 3'd2);

    // Reset state: result cleared before and across clock edges
    #2;
    chk("reset_result_pre_edge", result, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result_held", result, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Basic sequence
    step("add",  16'b000_000_001_0000_010, 16'd50);
    step("addi", 16'b001_000_001_0000001,  16'd21);
    step("subi", 16'b010_000_001_0000001,  16'd19);
    step("sub",  16'b011_000_001_0000_010, 16'hFFF6);
    read_reg(3'd0, 16'hFFF6);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_clear", result, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) read_reg(i[2:0], pre[i]);

    // Dependency
    step("dep_add_r3", rrr(3'b000, 3'd3, 3'd1, 3'd2), 16'd50);
    step("dep_add_r4", rrr(3'b000, 3'd4, 3'd3, 3'd0), 16'd60);

    // Negative immediates
    step("addi_neg1",  rri(3'b001, 3'd5, 3'd0, 7'h7F), 16'd9);
    step("subi_neg64", rri(3'b010, 3'd6, 3'd0, 7'h40), 16'd74);

    // Logic ops and NOP
    step("nand", rrr(3'b100, 3'd7, 3'd1, 3'd2), 16'hFFEB);
    step("or",   rrr(3'b110, 3'd7, 3'd1, 3'd2), 16'h001E);
    step("and",  rrr(3'b101, 3'd7, 3'd1, 3'd2), 16'h0014);
    step("nop",  rri(3'b111, 3'd1, 3'd2, 7'h7F), 16'h0014);
    read_reg(3'd1, 16'd20);
    read_reg(3'd3, 16'd50);
    read_reg(3'd4, 16'd60);
    read_reg(3'd5, 16'd9);
    read_reg(3'd6, 16'd74);
    read_reg(3'd7, 16'h0014);

    // rA equals rB: old operand used, new value visible next edge
    step("self_add_r1", rrr(3'b000, 3'd1, 3'd1, 3'd1), 16'd40);
    read_reg(3'd1, 16'd40);

    // Reset pulse mid-run reloads the preload
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    read_reg(3'd3, 16'd0);
    read_reg(3'd1, 16'd20);
    step("post_reset_add", rrr(3'b000, 3'd0, 3'd1, 3'd2), 16'd50);
    read_reg(3'd0, 16'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
